// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-port memory, one transaction in flight
// Data has priority; a streak counter forces a fetch grant after MAX_DM_STREAK data grants.
module mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_DM_STREAK = 4,
   parameter int TIMEOUT       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              bus_err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] IF_WAIT = 2'd1;
   localparam logic [1:0] DM_WAIT = 2'd2;

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int STRK_W = $clog2(MAX_DM_STREAK + 1);

   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [STRK_W-1:0] streak_q, streak_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              dm_ready_q, dm_ready_d;
   logic              bus_err_q, bus_err_d;

   logic streak_full;
   logic fetch_win;
   logic timed_out;

   assign streak_full = (streak_q == STRK_W'(MAX_DM_STREAK));
   assign fetch_win   = if_req && (!dm_req || streak_full);
   // An ack arriving on the last allowed wait cycle wins over the timeout.
   assign timed_out   = !mem_ack && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      streak_d    = streak_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      bus_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               mem_en_d   = 1'b1;
               wait_cnt_d = '0;
               if (fetch_win) begin
                  state_d     = IF_WAIT;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  streak_d    = '0;
               end else begin
                  state_d     = DM_WAIT;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  if (!if_req) begin
                     streak_d = '0;
                  end else if (!streak_full) begin
                     streak_d = streak_q + STRK_W'(1);
                  end
               end
            end
         end
         IF_WAIT, DM_WAIT: begin
            if (mem_ack) begin
               if (state_q == IF_WAIT) begin
                  if_rdata_d = mem_rdata;
               end else if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            if (mem_ack || timed_out) begin
               if_ready_d = (state_q == IF_WAIT);
               dm_ready_d = (state_q == DM_WAIT);
               bus_err_d  = timed_out;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         streak_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         streak_q    <= streak_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

   localparam int TO   = 16;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_en, mem_we, bus_err;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
   );

   int checks = 0;
   int errors = 0;

   // reference model: one outstanding transaction, expected outputs after each edge
   bit          m_busy, m_is_dm;
   int          m_elapsed, m_streak;
   bit          e_mem_en, e_we, e_if_ready, e_dm_ready, e_bus_err;
   logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;

   // memory responder and requester agents
   int          resp_left = -1;
   int          resp_fixed = 1;
   bit          fixed_rd_en = 1'b0;
   logic [31:0] fixed_rd = '0;
   bit          auto_req = 1'b0;
   bit          stray_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      m_busy = 0; m_is_dm = 0; m_elapsed = 0; m_streak = 0;
      e_mem_en = 0; e_we = 0; e_if_ready = 0; e_dm_ready = 0; e_bus_err = 0;
      e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
   endfunction

   function automatic void model_edge(input bit s_if, input bit s_dm, input bit s_ack,
                                      input logic [31:0] s_rd, input logic [31:0] s_ifa,
                                      input bit s_we, input logic [31:0] s_dma,
                                      input logic [31:0] s_wd);
      bit fetch_wins;
      e_if_ready = 0; e_dm_ready = 0; e_bus_err = 0; e_mem_en = 0;
      if (m_busy) begin
         if (s_ack) begin
            m_busy = 0;
            if (m_is_dm) begin
               e_dm_ready = 1;
               if (!e_we) e_dm_rdata = s_rd;
            end else begin
               e_if_ready = 1;
               e_if_rdata = s_rd;
            end
         end else begin
            m_elapsed++;
            if (m_elapsed >= TO) begin
               m_busy = 0;
               e_bus_err = 1;
               if (m_is_dm) e_dm_ready = 1;
               else         e_if_ready = 1;
            end
         end
      end else if (s_if || s_dm) begin
         fetch_wins = s_if && (!s_dm || m_streak >= MAXS);
         m_busy = 1; m_elapsed = 0; e_mem_en = 1;
         if (fetch_wins) begin
            m_is_dm = 0; e_we = 0; e_addr = s_ifa; e_wdata = '0; m_streak = 0;
         end else begin
            m_is_dm = 1; e_we = s_we; e_addr = s_dma; e_wdata = s_wd;
            m_streak = s_if ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
         end
      end
   endfunction

   task automatic check_outputs();
      chk("mem_en",    32'(mem_en),    32'(e_mem_en));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  mem_addr,       e_addr);
      chk("mem_wdata", mem_wdata,      e_wdata);
      chk("if_ready",  32'(if_ready),  32'(e_if_ready));
      chk("dm_ready",  32'(dm_ready),  32'(e_dm_ready));
      chk("bus_err",   32'(bus_err),   32'(e_bus_err));
      chk("if_rdata",  if_rdata,       e_if_rdata);
      chk("dm_rdata",  dm_rdata,       e_dm_rdata);
      chk("ready_excl", 32'(if_ready & dm_ready), 32'(0));
   endtask

   function automatic int pick_lat();
      int lat_tab[8] = '{0, 1, 1, 2, 3, 15, 16, -1};
      if (resp_fixed != -2) return resp_fixed;
      return lat_tab[$urandom_range(0, 7)];
   endfunction

   task automatic drive_resp();
      mem_rdata = fixed_rd_en ? fixed_rd : $urandom;
      if (!reset) resp_left = -1;
      else if (mem_en) resp_left = pick_lat();
      if (resp_left == 0) begin
         mem_ack = 1'b1;
         resp_left = -1;
      end else begin
         mem_ack = stray_en && (resp_left < 0) && ($urandom_range(0, 19) == 0);
         if (resp_left > 0) resp_left--;
      end
   endtask

   task automatic drive_agents();
      if (if_req) begin
         if (if_ready) begin
            if ($urandom_range(0, 3) == 0) if_addr = $urandom;
            else                           if_req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         if_req = 1'b1; if_addr = $urandom;
      end
      if (dm_req) begin
         if (dm_ready) begin
            if ($urandom_range(0, 3) == 0) begin
               dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
            end else dm_req = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
   endtask

   task automatic step();
      bit          s_if, s_dm, s_ack, s_we;
      logic [31:0] s_rd, s_ifa, s_dma, s_wd;
      s_if = if_req; s_dm = dm_req; s_ack = mem_ack; s_we = dm_we;
      s_rd = mem_rdata; s_ifa = if_addr; s_dma = dm_addr; s_wd = dm_wdata;
      @(posedge clk);
      if (!reset) model_clear();
      else        model_edge(s_if, s_dm, s_ack, s_rd, s_ifa, s_we, s_dma, s_wd);
      #1;
      check_outputs();
      drive_resp();
      if (auto_req) drive_agents();
   endtask

   initial begin
      int          n, g, dm_seen, if_seen;
      logic [31:0] saved;
      logic [31:0] kind[10];

      reset = 1'b0;
      if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
      model_clear();
      repeat (3) step();
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_if_rdata", if_rdata, 32'h0);

      // fetch read right out of reset, ack one cycle after mem_en
      reset = 1'b1;
      fixed_rd_en = 1'b1; fixed_rd = 32'h0050_0093; resp_fixed = 1;
      if_req = 1'b1; if_addr = 32'h100;
      step();
      chk("f_mem_en", 32'(mem_en), 32'(1));
      chk("f_mem_addr", mem_addr, 32'h100);
      step();
      chk("f_mem_en_pulse", 32'(mem_en), 32'(0));
      step();
      chk("f_if_ready", 32'(if_ready), 32'(1));
      chk("f_if_rdata", if_rdata, 32'h0050_0093);
      if_req = 1'b0;
      step();
      chk("f_if_ready_pulse", 32'(if_ready), 32'(0));
      chk("f_if_rdata_hold", if_rdata, 32'h0050_0093);
      fixed_rd_en = 1'b0;

      // simultaneous requests: data write first, then fetch
      saved = dm_rdata;
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("s_mem_we", 32'(mem_we), 32'(1));
      chk("s_mem_addr", mem_addr, 32'h200);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      dm_seen = -1; if_seen = -1;
      for (int i = 1; i <= 30 && (dm_seen < 0 || if_seen < 0); i++) begin
         step();
         if (dm_ready && dm_seen < 0) begin dm_seen = i; dm_req = 1'b0; end
         if (if_ready && if_seen < 0) begin if_seen = i; if_req = 1'b0; end
      end
      chk("s_dm_done_cycle", 32'(dm_seen), 32'(2));
      chk("s_if_done_cycle", 32'(if_seen), 32'(5));
      chk("s_write_keeps_rdata", dm_rdata, saved);

      // both held: 4 data grants then 1 fetch, repeating
      if_req = 1'b1; if_addr = 32'h500;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
      g = 0;
      for (int i = 0; i < 80 && g < 10; i++) begin
         step();
         if (mem_en) begin kind[g] = mem_addr; g++; end
      end
      chk("k_grant_count", 32'(g), 32'(10));
      for (int i = 0; i < 10; i++)
         chk($sformatf("k_grant%0d", i), kind[i], (i % 5 == 4) ? 32'h500 : 32'h400);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (4) step();

      // data read with no ack: timeout with bus_err, rdata untouched
      resp_fixed = -1;
      saved = dm_rdata;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
      step();
      chk("t_mem_en", 32'(mem_en), 32'(1));
      n = 0;
      do begin step(); n++; end while (!dm_ready && n < 40);
      chk("t_timeout_cycles", 32'(n), 32'(TO));
      chk("t_bus_err", 32'(bus_err), 32'(1));
      chk("t_dm_rdata_kept", dm_rdata, saved);
      dm_req = 1'b0; resp_fixed = 1;
      if_req = 1'b1; if_addr = 32'h700;
      step();
      chk("t_next_grant", mem_addr, 32'h700);
      step(); step();
      chk("t_next_ready", 32'(if_ready), 32'(1));
      chk("t_next_no_err", 32'(bus_err), 32'(0));
      if_req = 1'b0;
      step();

      // reset mid fetch, then a late ack after release
      resp_fixed = -1;
      if_req = 1'b1; if_addr = 32'h800;
      step(); step();
      reset = 1'b0;
      #1;
      model_clear();
      chk("r_async_mem_en", 32'(mem_en), 32'(0));
      chk("r_async_addr", mem_addr, 32'h0);
      chk("r_async_if_rdata", if_rdata, 32'h0);
      if_req = 1'b0;
      step(); step();
      reset = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("r_no_if_ready", 32'(if_ready), 32'(0));
      end

      // randomized traffic with random latency, timeouts and stray acks
      resp_fixed = -2; stray_en = 1'b1; auto_req = 1'b1;
      repeat (3000) step();
      auto_req = 1'b0; stray_en = 1'b0; resp_fixed = 1;
      if_req = 1'b0; dm_req = 1'b0;
      repeat (40) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MAX_DM_STREAK, default 4, consecutive data grants allowed while a fetch is pending.
REQ-004 Parameter TIMEOUT, default 16, wait cycles for mem_ack before abort.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data.
- if_ready  out  1  fetch completion pulse.
- dm_req  in  1  data request, level.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data.
- dm_ready  out  1  data completion pulse.
- mem_en  out  1  single-port memory strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion pulse.
- bus_err  out  1  pulses with the ready of a timed-out transaction.

Function
REQ-006 FSM states SHALL be IDLE, IF_WAIT and DM_WAIT; exactly one transaction is outstanding at a time.
REQ-007 In IDLE, a sampled request SHALL be granted and issued. Next cycle: mem_en=1, mem_we/mem_addr/mem_wdata from the granted requester, state becomes IF_WAIT or DM_WAIT.
REQ-008 mem_en SHALL be high for exactly one cycle per grant. mem_addr, mem_we and mem_wdata SHALL hold until the transaction ends.
REQ-009 Priority SHALL be data over fetch, except when the data-streak counter equals MAX_DM_STREAK and if_req=1; then fetch wins.
REQ-010 Data-streak counter SHALL:
- increment on each data grant while if_req=1;
- clear on each fetch grant, and on a data grant while if_req=0;
- saturate at MAX_DM_STREAK.
REQ-011 In a WAIT state, mem_ack SHALL cause, on the next cycle:
- mem_rdata captured into if_rdata (IF_WAIT) or dm_rdata (DM_WAIT read);
- the matching ready pulsed high for one cycle;
- return to IDLE.
REQ-012 A data write SHALL pulse dm_ready with dm_rdata unchanged.
REQ-013 if_rdata and dm_rdata SHALL hold their value until their next completion.
REQ-014 Minimum latency SHALL be 3 cycles from request sample to ready: grant cycle N, mem_en N+1, mem_ack N+2, ready N+3. The next grant may be sampled in the ready cycle.
REQ-015 Requesters SHALL hold req, address and write data stable until their ready. A request dropped early still completes and pulses ready.
REQ-016 Wait counter SHALL clear on issue and increment each WAIT cycle without mem_ack. On reaching TIMEOUT the arbiter SHALL:
- pulse the matching ready together with bus_err;
- leave rdata unchanged;
- return to IDLE.
REQ-017 mem_ack in IDLE (stray or late) SHALL be ignored, with no ready or state change.
REQ-018 mem_ack in the same cycle as a timeout SHALL count as a normal completion with bus_err=0.
REQ-019 if_ready and dm_ready SHALL never be high in the same cycle.

Reset
REQ-020 While reset=0, all of the following SHALL be 0: state (IDLE), counters, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, bus_err.
REQ-021 Reset asserted mid-transaction SHALL abandon it without a ready pulse. A mem_ack after deassertion falls under REQ-017.
REQ-022 First grant SHALL be sampled on the first rising edge after reset deasserts.

Verification
REQ-023 Fetch read, if_addr=0x100, mem_ack 1 cycle after mem_en, mem_rdata=0x00500093 -> mem_en one cycle with mem_addr=0x100; if_ready at N+3; if_rdata=0x00500093.
REQ-024 Simultaneous if_req and dm_req (write, dm_addr=0x200, dm_wdata=0xDEADBEEF) -> data first with mem_we=1; dm_ready; then fetch granted; if_ready; the two readies never coincide.
REQ-025 dm_req held continuously with if_req=1 -> exactly 4 data grants, 1 fetch grant, repeating.
REQ-026 No mem_ack after a data read issue -> dm_ready and bus_err pulse together 16 cycles after mem_en; dm_rdata unchanged; arbiter accepts the next request.
REQ-027 reset pulled low during IF_WAIT, then mem_ack after release -> all outputs 0 during reset; no if_ready; stray ack ignored.
